// File: rtl/tlul_pkg.sv
// tlul_pkg
// Shared TL-UL channel types and opcode constants used by device-side
// responders on the device mux.
//   tl_h2d_t : host-to-device A channel plus d_ready
//   tl_d2h_t : device-to-host D channel plus a_ready
//   rsp_state_e : occupancy of a single-entry response register
package tlul_pkg;

   // A-channel opcodes
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;

   // D-channel opcodes
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   // Largest legal a_size (log2 bytes) on a 32-bit bus
   localparam logic [1:0] MaxSize        = 2'd2;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [15:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/tlul_regfile.sv
// tlul_regfile
// TL-UL device-side register bank. Decodes Get/PutFullData/PutPartialData,
// applies byte-masked writes to RW registers, serves reads from the register
// array or from hardware status inputs (RO registers), and returns one
// registered AccessAck/AccessAckData response with pass-through backpressure.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   tl_i       : A channel + d_ready from host/mux
//   tl_o       : D channel + a_ready to host/mux
//   reg_o      : current register contents (RO entries drive 0)
//   hw_i       : hardware status values read through RO registers
//   wr_pulse_o : one-cycle strobe per RW register after an accepted write
module tlul_regfile
   import tlul_pkg::*;
#(
   parameter int unsigned                NUM_REGS  = 8,
   parameter logic [NUM_REGS-1:0][31:0]  RESET_VAL = '0,
   parameter logic [NUM_REGS-1:0]        RO_MASK   = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  tl_h2d_t                       tl_i,
   output tl_d2h_t                       tl_o,
   output logic [NUM_REGS-1:0][31:0]     reg_o,
   input  logic [NUM_REGS-1:0][31:0]     hw_i,
   output logic [NUM_REGS-1:0]           wr_pulse_o
);

   // ------------------------------------------------------------------
   // Response register state
   // ------------------------------------------------------------------
   rsp_state_e  rsp_state_q;
   logic [2:0]  d_opcode_q;
   logic [1:0]  d_size_q;
   logic [7:0]  d_source_q;
   logic [31:0] d_data_q;
   logic        d_error_q;

   logic        d_valid;
   logic        a_ready;
   logic        a_hs;

   assign d_valid = (rsp_state_q == RSP_FULL);
   // The slot frees up in the same cycle the host takes the current
   // response, so a_ready depends only on d_ready and never on a_valid.
   assign a_ready = ~d_valid | tl_i.d_ready;
   assign a_hs    = tl_i.a_valid & a_ready;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [7:0]  idx;
   logic        is_get;
   logic        is_put;
   logic        idx_ok;
   logic        req_err;
   logic        wr_en;

   assign idx     = tl_i.a_address[9:2];
   assign is_get  = (tl_i.a_opcode == Get);
   assign is_put  = (tl_i.a_opcode == PutFullData) |
                    (tl_i.a_opcode == PutPartialData);
   // One extra bit so NUM_REGS = 256 compares correctly.
   assign idx_ok  = ({1'b0, idx} < 9'(NUM_REGS));

   assign req_err = ~(is_get | is_put)
                  | (tl_i.a_size > MaxSize)
                  | (tl_i.a_address[1:0] != 2'b00)
                  | ~idx_ok
                  | ((tl_i.a_opcode == PutFullData) & (tl_i.a_mask != 4'hF));

   assign wr_en   = a_hs & is_put & ~req_err;

   // ------------------------------------------------------------------
   // Register array: one generate slice per register
   // ------------------------------------------------------------------
   logic [NUM_REGS-1:0][31:0] rd_val;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
         assign rd_val[gi]     = hw_i[gi];
         assign reg_o[gi]      = '0;
         assign wr_pulse_o[gi] = 1'b0;
      end else begin : g_rw
         logic [31:0] val_q;
         logic        pulse_q;
         logic        sel;

         assign sel = wr_en & (idx == 8'(gi));

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               val_q   <= RESET_VAL[gi];
               pulse_q <= 1'b0;
            end else begin
               pulse_q <= sel;
               for (int b = 0; b < 4; b++) begin
                  if (sel && tl_i.a_mask[b]) begin
                     val_q[8*b +: 8] <= tl_i.a_data[8*b +: 8];
                  end
               end
            end
         end

         assign rd_val[gi]     = val_q;
         assign reg_o[gi]      = val_q;
         assign wr_pulse_o[gi] = pulse_q;
      end
   end

   // Read mux; out-of-range indices fall through to zero (they are errors).
   logic [31:0] rdata;
   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (idx == 8'(k)) begin
            rdata = rd_val[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Response register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_state_q <= RSP_EMPTY;
         d_opcode_q  <= '0;
         d_size_q    <= '0;
         d_source_q  <= '0;
         d_data_q    <= '0;
         d_error_q   <= 1'b0;
      end else begin
         case (rsp_state_q)
            RSP_EMPTY: begin
               if (a_hs) begin
                  rsp_state_q <= RSP_FULL;
               end
            end
            RSP_FULL: begin
               if (tl_i.d_ready && !a_hs) begin
                  rsp_state_q <= RSP_EMPTY;
               end
            end
            default: rsp_state_q <= RSP_EMPTY;
         endcase

         // Fields only move on a new request; while the host stalls,
         // a_ready is low so they stay put.
         if (a_hs) begin
            d_opcode_q <= is_get ? AccessAckData : AccessAck;
            d_size_q   <= tl_i.a_size;
            d_source_q <= tl_i.a_source;
            d_error_q  <= req_err;
            d_data_q   <= (is_get && !req_err) ? rdata : '0;
         end
      end
   end

   always_comb begin
      tl_o          = '0;
      tl_o.d_valid  = d_valid;
      tl_o.d_opcode = d_opcode_q;
      tl_o.d_param  = '0;
      tl_o.d_size   = d_size_q;
      tl_o.d_source = d_source_q;
      tl_o.d_sink   = 1'b0;
      tl_o.d_data   = d_data_q;
      tl_o.d_user   = '0;
      tl_o.d_error  = d_error_q;
      tl_o.a_ready  = a_ready;
   end

   // Fields that carry no meaning for this device (device select bits are
   // resolved upstream by the mux; hw_i is only consumed for RO slots).
   logic unused_inputs;
   assign unused_inputs = ^{tl_i.a_param, tl_i.a_address[31:10], hw_i};

endmodule

// File: tb/tb_tlul_regfile.sv
module tb_tlul_regfile;
   import tlul_pkg::*;

   localparam int N = 8;
   localparam logic [N-1:0][31:0] RV = {
      32'h7070_7070, 32'h6060_6060, 32'h5050_5050, 32'h4040_4040,
      32'h3030_3030, 32'h2020_2020, 32'h1010_1010, 32'h0102_0304};
   localparam logic [N-1:0] RO = 8'b0010_0100;

   logic                clk = 1'b0;
   logic                rst_n;
   tl_h2d_t             tl_i;
   tl_d2h_t             tl_o;
   logic [N-1:0][31:0]  reg_o;
   logic [N-1:0][31:0]  hw_i;
   logic [N-1:0]        wr_pulse;

   tlul_regfile #(
      .NUM_REGS  (N),
      .RESET_VAL (RV),
      .RO_MASK   (RO)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .tl_i       (tl_i),
      .tl_o       (tl_o),
      .reg_o      (reg_o),
      .hw_i       (hw_i),
      .wr_pulse_o (wr_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [7:0]  src;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic [31:0] m_regs [N];
   rsp_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          a_hs_seen = 0;
   int          d_hs_seen = 0;

   function automatic bit model_err(input logic [2:0] op, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [3:0] mask);
      int idx;
      idx = int'(addr[9:2]);
      if (!(op == 3'd4 || op == 3'd0 || op == 3'd1)) return 1'b1;
      if (size > 2'd2) return 1'b1;
      if (addr[1:0] != 2'b00) return 1'b1;
      if (idx >= N) return 1'b1;
      if (op == 3'd0 && mask != 4'hF) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_regs[k] = RV[k];
      exp_q.delete();
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] e;
      for (int k = 0; k < N; k++) begin
         e = RO[k] ? 32'h0 : m_regs[k];
         n_checks++;
         if (reg_o[k] !== e) begin
            n_fail++;
            $display("FAIL %s reg_o[%0d] got=%h exp=%h", tag, k, reg_o[k], e);
         end
      end
   endtask

   // One clock of bus activity: drive at negedge, check, then advance to
   // the next negedge and check the write side effects.
   task automatic step(input logic av, input logic [2:0] op, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data,
                       input logic [1:0] size, input logic [7:0] src,
                       input logic dr, input string tag);
      bit          exp_ar;
      bit          ahs;
      bit          dhs;
      bit          e;
      int          idx;
      rsp_t        r;
      logic [N-1:0] np;
      tl_i.a_valid   = av;
      tl_i.a_opcode  = op;
      tl_i.a_param   = 3'($urandom);
      tl_i.a_size    = size;
      tl_i.a_source  = src;
      tl_i.a_address = addr;
      tl_i.a_mask    = mask;
      tl_i.a_data    = data;
      tl_i.d_ready   = dr;
      #1;
      exp_ar = (exp_q.size() == 0) || dr;
      n_checks++;
      if (tl_o.a_ready !== exp_ar) begin
         n_fail++;
         $display("FAIL %s a_ready got=%b exp=%b", tag, tl_o.a_ready, exp_ar);
      end
      n_checks++;
      if (tl_o.d_valid !== (exp_q.size() != 0)) begin
         n_fail++;
         $display("FAIL %s d_valid got=%b exp=%b", tag, tl_o.d_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
         r = exp_q[0];
         n_checks++;
         if ({tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error} !==
             {r.op, r.size, r.src, r.data, r.err}) begin
            n_fail++;
            $display("FAIL %s d_rsp got op=%0d sz=%0d src=%h data=%h err=%b exp op=%0d sz=%0d src=%h data=%h err=%b",
                     tag, tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error,
                     r.op, r.size, r.src, r.data, r.err);
         end
         n_checks++;
         if ({tl_o.d_param, tl_o.d_sink, tl_o.d_user} !== 20'h0) begin
            n_fail++;
            $display("FAIL %s d_zero_fields got param=%0d sink=%b user=%h exp 0",
                     tag, tl_o.d_param, tl_o.d_sink, tl_o.d_user);
         end
      end
      if (av && tl_o.a_ready) a_hs_seen++;
      if (tl_o.d_valid && dr) d_hs_seen++;

      dhs = (exp_q.size() != 0) && dr;
      ahs = av && exp_ar;
      np  = '0;
      if (dhs) void'(exp_q.pop_front());
      if (ahs) begin
         e      = model_err(op, size, addr, mask);
         idx    = int'(addr[9:2]);
         r.op   = (op == 3'd4) ? 3'd1 : 3'd0;
         r.size = size;
         r.src  = src;
         r.err  = e;
         r.data = 32'h0;
         if (!e && op == 3'd4) r.data = RO[idx] ? hw_i[idx] : m_regs[idx];
         if (!e && op != 3'd4 && !RO[idx]) begin
            for (int b = 0; b < 4; b++)
               if (mask[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
            np[idx] = 1'b1;
         end
         exp_q.push_back(r);
         $display("txn %s op=%0d addr=%h mask=%h data=%h size=%0d src=%h -> err=%b rdata=%h",
                  tag, op, addr, mask, data, size, src, e, r.data);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (wr_pulse !== np) begin
         n_fail++;
         $display("FAIL %s wr_pulse got=%b exp=%b", tag, wr_pulse, np);
      end
      check_regs(tag);
   endtask

   task automatic idle(input logic dr);
      step(1'b0, 3'd4, $urandom, 4'hF, $urandom, 2'd2, 8'h00, dr, "idle");
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      tl_i  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (tl_o !== tl_d2h_t'({1'b0, 3'd0, 3'd0, 2'd0, 8'd0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b1})) begin
         n_fail++;
         $display("FAIL reset tl_o got=%h exp d_*=0 a_ready=1", tl_o);
      end
      n_checks++;
      if (wr_pulse !== '0) begin
         n_fail++;
         $display("FAIL reset wr_pulse got=%b exp=0", wr_pulse);
      end
      check_regs("reset");
      @(negedge clk);
   endtask

   task automatic test_write_read();
      step(1'b1, 3'd0, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 2'd2, 8'h5A, 1'b1, "putfull");
      step(1'b1, 3'd4, 32'h0000_0004, 4'hF, 32'h0, 2'd2, 8'hA5, 1'b1, "get");
      idle(1'b1);
      step(1'b1, 3'd1, 32'h0000_0004, 4'b0010, 32'h0000_AA00, 2'd2, 8'h11, 1'b1, "putpartial");
      step(1'b1, 3'd4, 32'h0000_0004, 4'hF, 32'h0, 2'd2, 8'h12, 1'b1, "get_partial");
      n_checks++;
      if (reg_o[1] !== 32'hDEAD_AAEF) begin
         n_fail++;
         $display("FAIL partial_value got=%h exp=deadaaef", reg_o[1]);
      end
      idle(1'b1);
   endtask

   task automatic test_errors();
      step(1'b1, 3'd4, 32'h0000_0002, 4'hF, 32'h0, 2'd2, 8'h21, 1'b1, "err_misalign");
      step(1'b1, 3'd4, 32'h0000_0020, 4'hF, 32'h0, 2'd2, 8'h22, 1'b1, "err_idx");
      step(1'b1, 3'd3, 32'h0000_0004, 4'hF, 32'h1234_5678, 2'd2, 8'h23, 1'b1, "err_opcode");
      step(1'b1, 3'd0, 32'h0000_0004, 4'h3, 32'hFFFF_FFFF, 2'd2, 8'h24, 1'b1, "err_mask");
      step(1'b1, 3'd1, 32'h0000_000C, 4'hF, 32'hFFFF_FFFF, 2'd3, 8'h25, 1'b1, "err_size");
      idle(1'b1);
   endtask

   task automatic test_backpressure();
      int d0;
      step(1'b1, 3'd4, 32'h0000_0000, 4'hF, 32'h0, 2'd2, 8'h30, 1'b1, "bp_first");
      for (int i = 0; i < 5; i++)
         step(1'b1, 3'd4, 32'h0000_0004, 4'hF, 32'h0, 2'd2, 8'h31, 1'b0, "bp_hold");
      d0 = d_hs_seen;
      for (int i = 0; i < 8; i++)
         step(1'b1, 3'd4, 32'(i * 4), 4'hF, 32'h0, 2'd2, 8'(8'h40 + i), 1'b1, "b2b_get");
      n_checks++;
      if (d_hs_seen - d0 !== 8) begin
         n_fail++;
         $display("FAIL b2b_throughput got=%0d responses exp=8", d_hs_seen - d0);
      end
      idle(1'b1);
   endtask

   task automatic test_ro();
      step(1'b1, 3'd0, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, 2'd2, 8'h50, 1'b1, "ro_put");
      step(1'b1, 3'd4, 32'h0000_0008, 4'hF, 32'h0, 2'd2, 8'h51, 1'b1, "ro_get");
      idle(1'b1);
   endtask

   task automatic test_random();
      logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd3, 3'd5};
      logic [2:0]  op;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [1:0]  size;
      for (int i = 0; i < 300; i++) begin
         op   = ops[$urandom_range(0, 5)];
         addr = $urandom;
         addr[9:0] = 10'($urandom_range(0, 9) * 4);
         if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         mask = 4'($urandom);
         if (op == 3'd0 && $urandom_range(0, 4) != 0) mask = 4'hF;
         size = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2;
         hw_i[5] = $urandom;
         step($urandom_range(0, 3) != 0, op, addr, mask, $urandom, size,
              8'($urandom), $urandom_range(0, 3) != 0, "rand");
      end
      idle(1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 3'd0, 32'h0000_0000, 4'hF, 32'h5555_AAAA, 2'd2, 8'h60, 1'b1, "mid_put");
      step(1'b1, 3'd4, 32'h0000_0000, 4'hF, 32'h0, 2'd2, 8'h61, 1'b0, "mid_get");
      #2;
      tl_i.a_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (tl_o.d_valid !== 1'b0 || tl_o.a_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset d_valid=%b a_ready=%b exp d_valid=0 a_ready=1",
                  tl_o.d_valid, tl_o.a_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      check_regs("mid_reset");
      idle(1'b1);
      step(1'b1, 3'd4, 32'h0000_0000, 4'hF, 32'h0, 2'd2, 8'h62, 1'b1, "post_reset_get");
      idle(1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      tl_i  = '0;
      for (int k = 0; k < N; k++) hw_i[k] = $urandom;
      hw_i[2] = 32'h1234_5678;
      test_reset();
      test_write_read();
      test_errors();
      test_backpressure();
      test_ro();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
